// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader slice.
package prog_loader_pkg;

   localparam int DEPTH     = 16;
   localparam int BANKS     = 2;
   localparam int WORD_W    = 8;
   localparam int CKSUM_LEN = 1;

   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      logic [0:0] mode;
      logic [3:0] addr;
   } virt_addr_t;

   typedef struct packed {
      virt_addr_t virt_addr;
   } addr_t;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] imm;
   } instruction_t;

   typedef struct packed {
      instruction_t instruction;
   } data_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2
   } loader_state_e;

   // Split a raw instruction byte into opcode / immediate fields.
   function automatic data_t word_to_data(input word_t w);
      data_t d;
      d.instruction.opcode = w[7:4];
      d.instruction.imm    = w[3:0];
      return d;
   endfunction

   // A load is good when the running sum plus the checksum byte wraps to zero.
   function automatic logic cksum_ok(input word_t acc, input word_t c);
      word_t total;
      total = acc + c;
      return (total == 8'h00);
   endfunction

endpackage

// File: rtl/prog_ram.sv
// Two-bank instruction store: synchronous write, asynchronous read.
module prog_ram
   import prog_loader_pkg::*;
(
   input  logic       clock,
   input  logic       we,
   input  logic [0:0] wr_bank,
   input  logic [3:0] wr_addr,
   input  word_t      wr_word,
   input  logic [0:0] rd_bank,
   input  logic [3:0] rd_addr,
   output word_t      rd_word
);

   word_t mem_r [BANKS][DEPTH];

   // Write port; contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (we) begin
         mem_r[wr_bank][wr_addr] <= wr_word;
      end
   end

   assign rd_word = mem_r[rd_bank][rd_addr];

endmodule

// File: rtl/prog_loader.sv
// Program-memory stage: serves fetches and loads a bank from a checksummed byte stream.
module prog_loader
   import prog_loader_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  addr_t      addr,
   output data_t      data,
   input  logic       load_start,
   input  logic       load_bank,
   input  logic       wr_valid,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic       cpu_hold,
   output logic       load_done,
   output logic       load_err,
   output logic [4:0] load_count
);

   loader_state_e    state_r;
   loader_state_e    state_n_s;
   logic [0:0]       bank_r;
   logic [BANKS-1:0] bank_valid_r;
   logic [4:0]       load_count_r;
   word_t            cksum_r;
   logic             load_done_r;
   logic             load_err_r;
   logic             wr_ready_r;
   logic             cpu_hold_r;
   logic             accept_s;
   logic             ram_we_s;
   word_t            rd_word_s;
   data_t            fetch_s;

   // A restart pulse takes priority over any byte presented in the same cycle.
   assign accept_s = wr_valid && wr_ready_r && !load_start;
   assign ram_we_s = accept_s && (state_r == LOAD);

   prog_ram u_ram (
      .clock   (clock),
      .we      (ram_we_s),
      .wr_bank (bank_r),
      .wr_addr (load_count_r[3:0]),
      .wr_word (wr_data),
      .rd_bank (addr.virt_addr.mode),
      .rd_addr (addr.virt_addr.addr),
      .rd_word (rd_word_s)
   );

   // Next-state decode for the loader FSM.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         IDLE: begin
            if (load_start) begin
               state_n_s = LOAD;
            end else begin
               state_n_s = IDLE;
            end
         end
         LOAD: begin
            if (load_start) begin
               state_n_s = LOAD;
            end else if (accept_s && (load_count_r == 5'(DEPTH - 1))) begin
               state_n_s = CHECK;
            end else begin
               state_n_s = LOAD;
            end
         end
         CHECK: begin
            if (load_start) begin
               state_n_s = LOAD;
            end else if (accept_s) begin
               state_n_s = IDLE;
            end else begin
               state_n_s = CHECK;
            end
         end
         default: begin
            state_n_s = IDLE;
         end
      endcase
   end

   // State register plus handshake/hold outputs registered from the next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= IDLE;
         wr_ready_r <= 1'b0;
         cpu_hold_r <= 1'b0;
      end else begin
         state_r    <= state_n_s;
         wr_ready_r <= (state_n_s != IDLE);
         cpu_hold_r <= (state_n_s != IDLE);
      end
   end

   // Load bookkeeping: target bank, valid bits, byte count, checksum and status.
   always_ff @(posedge clock) begin
      if (reset) begin
         bank_r       <= 1'b0;
         bank_valid_r <= '0;
         load_count_r <= 5'd0;
         cksum_r      <= 8'h00;
         load_done_r  <= 1'b0;
         load_err_r   <= 1'b0;
      end else begin
         load_done_r <= 1'b0;
         if (load_start) begin
            bank_r                  <= load_bank;
            bank_valid_r[load_bank] <= 1'b0;
            load_err_r              <= 1'b0;
            load_count_r            <= 5'd0;
            cksum_r                 <= 8'h00;
         end else if (accept_s && (state_r == LOAD)) begin
            cksum_r      <= cksum_r + wr_data;
            load_count_r <= load_count_r + 5'd1;
         end else if (accept_s && (state_r == CHECK)) begin
            load_count_r <= 5'(DEPTH + CKSUM_LEN);
            if (cksum_ok(cksum_r, wr_data)) begin
               bank_valid_r[bank_r] <= 1'b1;
               load_done_r          <= 1'b1;
            end else begin
               load_err_r <= 1'b1;
            end
         end
      end
   end

   // Fetch path: an invalid bank returns a harmless no-op instruction.
   always_comb begin
      fetch_s = word_to_data(8'h00);
      if (bank_valid_r[addr.virt_addr.mode]) begin
         fetch_s = word_to_data(rd_word_s);
      end else begin
         fetch_s = word_to_data(8'h00);
      end
   end

   assign data       = fetch_s;
   assign wr_ready   = wr_ready_r;
   assign cpu_hold   = cpu_hold_r;
   assign load_done  = load_done_r;
   assign load_err   = load_err_r;
   assign load_count = load_count_r;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table, directed sequences, random loads vs model.
module tb_prog_loader;
   import prog_loader_pkg::*;

   logic       clock;
   logic       reset;
   addr_t      addr;
   data_t      data;
   logic       load_start;
   logic       load_bank;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       cpu_hold;
   logic       load_done;
   logic       load_err;
   logic [4:0] load_count;

   int errors = 0;
   int checks = 0;

   prog_loader dut (
      .clock      (clock),
      .reset      (reset),
      .addr       (addr),
      .data       (data),
      .load_start (load_start),
      .load_bank  (load_bank),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err),
      .load_count (load_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model (byte list per load) ----------------
   logic [7:0] m_mem [2][16];
   bit         m_valid [2];
   bit         m_loading;
   int         m_bank;
   logic [7:0] m_q [$];
   int         m_count;
   bit         m_done;
   bit         m_err;

   function automatic logic [7:0] q_sum();
      logic [7:0] s = 8'h00;
      foreach (m_q[i]) s = s + m_q[i];
      return s;
   endfunction

   task automatic model_step(input logic rst, input logic ls, input logic lb,
                             input logic v, input logic [7:0] d);
      if (rst) begin
         m_loading = 0; m_valid[0] = 0; m_valid[1] = 0;
         m_count = 0; m_done = 0; m_err = 0; m_q.delete();
      end else begin
         m_done = 0;
         if (ls) begin
            m_loading = 1; m_bank = int'(lb); m_valid[m_bank] = 0;
            m_err = 0; m_count = 0; m_q.delete();
         end else if (m_loading && v) begin
            m_q.push_back(d);
            m_count = m_q.size();
            if (m_q.size() <= 16) begin
               m_mem[m_bank][m_q.size()-1] = d;
            end else begin
               m_loading = 0;
               if (q_sum() == 8'h00) begin
                  m_valid[m_bank] = 1; m_done = 1;
               end else begin
                  m_err = 1;
               end
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [7:0] exp_d;
      int md;
      md = int'(addr.virt_addr.mode);
      exp_d = m_valid[md] ? m_mem[md][addr.virt_addr.addr] : 8'h00;
      chk("model_wr_ready",   {31'd0, wr_ready},  {31'd0, m_loading});
      chk("model_cpu_hold",   {31'd0, cpu_hold},  {31'd0, m_loading});
      chk("model_load_count", {27'd0, load_count}, 32'(m_count));
      chk("model_load_done",  {31'd0, load_done}, {31'd0, m_done});
      chk("model_load_err",   {31'd0, load_err},  {31'd0, m_err});
      chk("model_data",       {24'd0, data},      {24'd0, exp_d});
   endtask

   // One clock: drive inputs, take the edge, advance the model, compare.
   task automatic cyc(input logic rst, input logic ls, input logic lb, input logic v,
                      input logic [7:0] d, input logic md, input logic [3:0] a);
      reset = rst; load_start = ls; load_bank = lb; wr_valid = v; wr_data = d;
      addr.virt_addr.mode = md; addr.virt_addr.addr = a;
      @(posedge clock);
      model_step(rst, ls, lb, v, d);
      #1;
      check_model();
   endtask

   // Full load: start pulse, 16 bytes base+i, then checksum byte.
   task automatic load_seq(input logic bk, input logic [7:0] base, input logic [7:0] ck,
                           input logic md, input logic [3:0] a, input logic [7:0] watch);
      cyc(1'b0, 1'b1, bk, 1'b0, 8'h00, md, a);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b0, bk, 1'b1, base + 8'(i), md, a);
         chk("hold_during_load", {31'd0, cpu_hold}, 32'd1);
         chk("watch_fetch", {24'd0, data}, {24'd0, watch});
      end
      cyc(1'b0, 1'b0, bk, 1'b1, ck, md, a);
   endtask

   typedef struct {
      logic ls; logic lb; logic v; logic [7:0] d;
      logic e_ready; logic [4:0] e_count; logic e_done; logic e_err; logic [7:0] e_data;
   } vec_t;

   vec_t vecs [6];
   logic [7:0] rd;
   logic [7:0] ck;
   int budget;

   initial begin
      reset = 1'b1; load_start = 1'b0; load_bank = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
      addr = '0;
      foreach (m_mem[b, i]) m_mem[b][i] = 8'h00;
      m_bank = 0;

      // Reset state
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd5);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd5);
      chk("reset_data",  {24'd0, data}, 32'h00);
      chk("reset_hold",  {31'd0, cpu_hold}, 32'd0);
      chk("reset_ready", {31'd0, wr_ready}, 32'd0);
      chk("reset_err",   {31'd0, load_err}, 32'd0);

      // Vector table: start of a bank-1 load with a stall and an ignored IDLE byte.
      vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 5'd1, 1'b0, 1'b0, 8'h00};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 8'hEE, 1'b1, 5'd1, 1'b0, 1'b0, 8'h00};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 5'd2, 1'b0, 1'b0, 8'h00};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 8'h00};
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, vecs[i].ls, vecs[i].lb, vecs[i].v, vecs[i].d, 1'b1, 4'd5);
         chk("vec_ready", {31'd0, wr_ready},   {31'd0, vecs[i].e_ready});
         chk("vec_count", {27'd0, load_count}, {27'd0, vecs[i].e_count});
         chk("vec_done",  {31'd0, load_done},  {31'd0, vecs[i].e_done});
         chk("vec_err",   {31'd0, load_err},   {31'd0, vecs[i].e_err});
         chk("vec_data",  {24'd0, data},       {24'd0, vecs[i].e_data});
      end
      // Finish bank 1 (A2..AF, checksum 0x88)
      for (int i = 2; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hA0 + 8'(i), 1'b1, 4'd5);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 4'd5);
      chk("b1_done",  {31'd0, load_done}, 32'd1);
      chk("b1_hold",  {31'd0, cpu_hold}, 32'd0);
      chk("b1_count", {27'd0, load_count}, 32'd17);
      chk("b1_addr5", {24'd0, data}, 32'hA5);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd5);
      chk("b1_done_pulse", {31'd0, load_done}, 32'd0);
      chk("b1_count_hold", {27'd0, load_count}, 32'd17);

      // Good load of bank 0 while fetching bank 1
      load_seq(1'b0, 8'h30, 8'h88, 1'b1, 4'd5, 8'hA5);
      chk("b0_done", {31'd0, load_done}, 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd3);
      chk("b0_addr3", {24'd0, data}, 32'h33);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd15);
      chk("b0_addr15", {24'd0, data}, 32'h3F);

      // Bad checksum
      load_seq(1'b0, 8'h30, 8'h89, 1'b0, 4'd3, 8'h00);
      chk("bad_err",  {31'd0, load_err}, 32'd1);
      chk("bad_done", {31'd0, load_done}, 32'd0);
      chk("bad_data", {24'd0, data}, 32'h00);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd3);
      chk("restart_clears_err", {31'd0, load_err}, 32'd0);

      // Restart at byte 7 with a byte presented in the restart cycle
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h30 + 8'(i), 1'b1, 4'd5);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 4'd5);
      chk("restart_count", {27'd0, load_count}, 32'd0);
      chk("restart_b1", {24'd0, data}, 32'hA5);
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h30 + 8'(i), 1'b1, 4'd5);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h88, 1'b0, 4'd7);
      chk("restart_done", {31'd0, load_done}, 32'd1);
      chk("restart_addr7", {24'd0, data}, 32'h37);

      // Toggling valid with random stalls: same contents
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      budget = 0;
      while (m_loading && budget < 200) begin
         budget++;
         rd = (m_q.size() < 16) ? 8'h30 + 8'(m_q.size()) : 8'h88;
         cyc(1'b0, 1'b0, 1'b0, (budget % 2 == 0) && ($urandom_range(0, 3) != 0), rd, 1'b0, 4'd9);
      end
      chk("toggle_finished", {31'd0, m_loading}, 32'd0);
      chk("toggle_addr9", {24'd0, data}, 32'h39);

      // Reset after byte 9 of a load
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 4'd5);
      for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 4'd5);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 4'd3);
      chk("rst_mid_hold",  {31'd0, cpu_hold}, 32'd0);
      chk("rst_mid_count", {27'd0, load_count}, 32'd0);
      chk("rst_mid_b0",    {24'd0, data}, 32'h00);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd5);
      chk("rst_mid_b1",    {24'd0, data}, 32'h00);

      // Random loads against the model
      for (int n = 0; n < 40; n++) begin
         cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'h00,
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         budget = 0;
         while (m_loading && budget < 300) begin
            budget++;
            if (m_q.size() == 16) begin
               ck = 8'h00 - q_sum();
               rd = ($urandom_range(0, 2) != 0) ? ck : 8'($urandom);
            end else begin
               rd = 8'($urandom);
            end
            cyc(($urandom_range(0, 400) == 0), ($urandom_range(0, 80) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), rd,
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         end
         for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
